// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word and RAM-status types, plus the arbiter FSM encoding.
// Contents:
//   word_t      - 32-bit machine word
//   ramstate_t  - RAM handshake status (FREE/BUSY/ACCESS/ERROR)
//   arb_state_t - mem_arbiter FSM state, with IDLE/IREQ/DREQ/RESP constants
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Plain vector plus constants so older code can compare against raw bit patterns.
  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE = 2'd0;
  localparam arb_state_t IREQ = 2'd1;
  localparam arb_state_t DREQ = 2'd2;
  localparam arb_state_t RESP = 2'd3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the signals between the fetch/data requesters, mem_arbiter and the RAM.
// Ports:
//   CLK  - system clock
//   nRST - asynchronous active-low reset
// Modports:
//   arb - arbiter side (requests and ramload/ramstate in; hits, load data, RAM command out)
//   tb  - requester/RAM side, the mirror image of arb
interface mem_arbiter_if
  import cpu_types_pkg::*;
(
  input logic CLK,
  input logic nRST
);

  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      ihit;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dhit;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      ramerr;

  modport arb (
    input  CLK, nRST,
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

  modport tb (
    input  CLK, nRST,
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

endinterface

// File: rtl/mem_arbiter.sv
// Sequential arbiter between the instruction-fetch port and the data port in front
// of a single-ported RAM. One access at a time: IDLE samples requests, IREQ/DREQ
// hold a registered RAM command until ACCESS (or ERROR), RESP pulses ihit/dhit.
// Data wins ties, but after DSTREAK_MAX consecutive data grants with a fetch
// waiting, the fetch is granted once.
// Ports:
//   CLK, nRST                - clock, asynchronous active-low reset
//   iREN, iaddr              - fetch request / address
//   iload, ihit              - fetched word, one-cycle completion pulse
//   dREN, dWEN, daddr, dstore- data read/write request, address, write data
//   dload, dhit              - read data, one-cycle completion pulse
//   ramREN, ramWEN           - RAM read/write strobes
//   ramaddr, ramstore        - RAM address / write data
//   ramload, ramstate        - RAM read data / handshake status
//   ramerr                   - sticky flag: RAM reported ERROR since reset
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned DSTREAK_MAX = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      ihit,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dhit,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      ramerr
);

  localparam int unsigned StreakW = $clog2(DSTREAK_MAX + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(DSTREAK_MAX);

  arb_state_t         state_q, state_d;
  word_t              addr_q, addr_d;
  word_t              store_q, store_d;
  logic               wr_q, wr_d;      // latched data access is a write
  logic               rd_q, rd_d;      // latched data access is a read (write wins)
  logic               data_q, data_d;  // access in flight belongs to the data port
  word_t              iload_q, iload_d;
  word_t              dload_q, dload_d;
  logic               err_q, err_d;
  logic [StreakW-1:0] streak_q, streak_d;

  logic data_pend;
  assign data_pend = dREN | dWEN;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    store_d  = store_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    data_d   = data_q;
    iload_d  = iload_q;
    dload_d  = dload_q;
    err_d    = err_q;
    streak_d = streak_q;

    unique case (state_q)
      IDLE: begin
        if (data_pend && (!iREN || (streak_q < StreakMax))) begin
          state_d = DREQ;
          addr_d  = daddr;
          store_d = dstore;
          wr_d    = dWEN;
          rd_d    = dREN & ~dWEN;
          data_d  = 1'b1;
          // Streak only counts data grants that bypassed a waiting fetch.
          if (!iREN) begin
            streak_d = '0;
          end else if (streak_q != StreakMax) begin
            streak_d = streak_q + StreakW'(1);
          end
        end else if (iREN) begin
          state_d  = IREQ;
          addr_d   = iaddr;
          wr_d     = 1'b0;
          rd_d     = 1'b0;
          data_d   = 1'b0;
          streak_d = '0;
        end
      end
      IREQ, DREQ: begin
        if (ramstate == ACCESS) begin
          state_d = RESP;
          if (state_q == IREQ) begin
            iload_d = ramload;
          end else if (rd_q) begin
            dload_d = ramload;
          end
        end else if (ramstate == ERROR) begin
          // Drop back to IDLE; the still-asserted request is re-sampled there.
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      store_q  <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      data_q   <= 1'b0;
      iload_q  <= '0;
      dload_q  <= '0;
      err_q    <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      iload_q  <= iload_d;
      dload_q  <= dload_d;
      err_q    <= err_d;
      streak_q <= streak_d;
    end
  end

  // Outputs decode registered state only.
  assign ramREN   = (state_q == IREQ) | ((state_q == DREQ) & rd_q);
  assign ramWEN   = (state_q == DREQ) & wr_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign ihit     = (state_q == RESP) & ~data_q;
  assign dhit     = (state_q == RESP) & data_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign ramerr   = err_q;

endmodule
